// File: rtl/load_store_unit.sv
// Load/store unit: RV32I byte/half/word accesses over a word-only data memory.
// Build with MISALIGN_TRAP_EN defined to reject misaligned accesses instead of aligning them.
module load_store_unit #(
    parameter int MEM_ADDR_W = 8
) (
    input  logic                  sysclk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic                  resp_err,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t                  state;
    logic [1:0]              off_q;
    logic [2:0]              funct3_q;
    logic                    we_q;
    logic [31:0]             wdata_q;

    logic                    illegal;
    logic                    misaligned;
    logic                    reject;
    logic [MEM_ADDR_W-1:0]   eff_addr;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:MEM_ADDR_W];

    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  extract_load = {{24{b[7]}}, b};
            3'b001:  extract_load = {{16{h[15]}}, h};
            3'b100:  extract_load = {24'h0, b};
            3'b101:  extract_load = {16'h0, h};
            default: extract_load = word;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off);
        merge_store = word;
        case (size)
            2'b00: begin
                case (off)
                    2'd0:    merge_store[7:0]   = wdata[7:0];
                    2'd1:    merge_store[15:8]  = wdata[7:0];
                    2'd2:    merge_store[23:16] = wdata[7:0];
                    default: merge_store[31:24] = wdata[7:0];
                endcase
            end
            2'b01: begin
                if (off[1])
                    merge_store[31:16] = wdata[15:0];
                else
                    merge_store[15:0]  = wdata[15:0];
            end
            default: merge_store = wdata;
        endcase
    endfunction

    // Stores only exist for byte/half/word; the unsigned encodings are load-only.
    always_comb begin
        illegal = 1'b1;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = req_we;
            default:                illegal = 1'b1;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign eff_addr   = req_addr[MEM_ADDR_W-1:0];
`else
    assign misaligned = 1'b0;

    always_comb begin
        eff_addr = req_addr[MEM_ADDR_W-1:0];
        if (req_funct3[1:0] == 2'b01)
            eff_addr[0] = 1'b0;
        else if (req_funct3[1:0] == 2'b10)
            eff_addr[1:0] = 2'b00;
    end
`endif

    assign reject = illegal | misaligned;

    // Every output is a register so mem_we drops the instant rst_n falls,
    // cancelling a write the memory has not yet taken on the falling edge.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= 32'h0;
            resp_err   <= 1'b0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'h0;
            off_q      <= 2'b00;
            funct3_q   <= 3'b000;
            we_q       <= 1'b0;
            wdata_q    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        off_q     <= eff_addr[1:0];
                        funct3_q  <= req_funct3;
                        we_q      <= req_we;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (reject) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= 32'h0;
                        end else if (req_we && (req_funct3 == 3'b010)) begin
                            state     <= WRITE;
                            mem_addr  <= {eff_addr[MEM_ADDR_W-1:2], 2'b00};
                            mem_we    <= 1'b1;
                            mem_wdata <= req_wdata;
                        end else begin
                            state    <= READ;
                            mem_addr <= {eff_addr[MEM_ADDR_W-1:2], 2'b00};
                            mem_re   <= 1'b1;
                        end
                    end
                end
                READ: begin
                    mem_re <= 1'b0;
                    if (we_q) begin
                        state     <= WRITE;
                        mem_we    <= 1'b1;
                        mem_wdata <= merge_store(mem_rdata, wdata_q, funct3_q[1:0], off_q);
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_data  <= extract_load(mem_rdata, funct3_q, off_q);
                    end
                end
                WRITE: begin
                    mem_we     <= 1'b0;
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_data  <= 32'h0;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_data  <= 32'h0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
